fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats enable, enable loads a valid instruction.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic [ADDR_WIDTH-1:0]  pc_plus4,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0]  pc_d,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_d,
  output logic                   valid_d
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= INSTR_WIDTH'(NOP_INSTR);
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush) begin
      // pc_d/pc_plus4_d are left stale; valid_d=0 marks them meaningless.
      instr_d <= INSTR_WIDTH'(NOP_INSTR);
      valid_d <= 1'b0;
    end else if (en) begin
      instr_d    <= instr;
      pc_d       <= pc;
      pc_plus4_d <= pc_plus4;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC/FSM (BOOT, RUN, HALT) driving external instruction memory.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  pc,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  input  logic                   halt_req,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0]  pc_d,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_d,
  output logic                   valid_d,
  output logic                   misalign_fault,
  output logic [31:0]            fetch_count
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  redirect_taken;
  logic                  target_misaligned;
  logic                  load;
  logic                  flush;

  assign pc_plus4          = pc + ADDR_WIDTH'(4);
  assign redirect_taken    = redirect && (state != BOOT);
  assign target_misaligned = |redirect_target[1:0];
  assign load              = (state == RUN) && !stall && !redirect;
  assign flush             = redirect_taken || (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      misalign_fault <= 1'b0;
      fetch_count    <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        default: begin
          if (redirect) begin
            pc <= {redirect_target[ADDR_WIDTH-1:2], 2'b00};
            if (target_misaligned) begin
              misalign_fault <= 1'b1;
              state          <= HALT;
            end else begin
              state <= RUN;
            end
          end else if (state == RUN) begin
            if (!stall) begin
              pc <= pc_plus4;
              if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
            end
            // The fetch in this cycle still completes; HALT starts next cycle.
            if (halt_req) state <= HALT;
          end
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (load),
    .flush     (flush),
    .instr     (instr),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc_plus4_d(pc_plus4_d),
    .valid_d   (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a cycle model and per-cycle compare.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall, redirect, halt_req;
  logic [31:0] redirect_target;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, misalign_fault;
  logic [31:0] fetch_count;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return ~a;
  endfunction

  assign instr = rom(pc);

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instr          (instr),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d),
    .misalign_fault (misalign_fault),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: mode 0 = just out of reset, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_instr_d, m_pc_d, m_pc4_d, m_cnt;
  logic        m_valid, m_fault;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = RPC; m_instr_d = NOP; m_pc_d = 0; m_pc4_d = 0;
      m_valid = 0; m_fault = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (redirect) begin
      m_valid = 0; m_instr_d = NOP;
      m_pc = redirect_target & 32'hFFFF_FFFC;
      if (redirect_target % 4 != 0) begin m_fault = 1; m_mode = 2; end
      else m_mode = 1;
    end else if (m_mode == 1) begin
      if (!stall) begin
        m_instr_d = rom(m_pc); m_pc_d = m_pc; m_pc4_d = m_pc + 4; m_valid = 1;
        m_pc = m_pc + 4;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      if (halt_req) m_mode = 2;
    end else begin
      m_valid = 0; m_instr_d = NOP;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("instr_d", instr_d, m_instr_d);
      check("valid_d", valid_d, m_valid);
      check("misalign_fault", misalign_fault, m_fault);
      check("fetch_count", fetch_count, m_cnt);
      if (m_valid) begin
        check("pc_d", pc_d, m_pc_d);
        check("pc_plus4_d", pc_plus4_d, m_pc4_d);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; redirect = 0; halt_req = 0; redirect_target = '0;
    tick(2);
    check("rst_pc", pc, RPC);
    check("rst_instr_d", instr_d, NOP);
    check("rst_valid", valid_d, 1'b0);
    check("rst_count", fetch_count, 0);
    check("rst_pc_d", pc_d, 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Boot cycle, then three sequential fetches.
    tick();
    check("boot_valid", valid_d, 1'b0);
    check("boot_pc", pc, RPC);
    tick();
    check("first_instr", instr_d, 32'h403F_FFFF);
    check("first_pc_d", pc_d, 32'hBFC0_0000);
    tick(2);
    check("third_instr", instr_d, 32'h403F_FFF7);
    check("third_pc_d", pc_d, 32'hBFC0_0008);
    check("third_count", fetch_count, 3);

    // Two-cycle stall holds everything.
    stall = 1; tick(2);
    check("stall_pc", pc, 32'hBFC0_000C);
    check("stall_instr", instr_d, 32'h403F_FFF7);
    check("stall_count", fetch_count, 3);
    stall = 0; tick();
    check("resume_pc_d", pc_d, 32'hBFC0_000C);
    check("resume_count", fetch_count, 4);

    // Redirect overrides a simultaneous stall.
    stall = 1; redirect = 1; redirect_target = 32'hBFC0_0100; tick();
    check("redir_pc", pc, 32'hBFC0_0100);
    check("redir_nop", instr_d, NOP);
    check("redir_valid", valid_d, 1'b0);
    stall = 0; redirect = 0; tick();
    check("redir_instr", instr_d, 32'h403F_FEFF);
    check("redir_pc_d", pc_d, 32'hBFC0_0100);

    // Misaligned target: fault, aligned pc, halted until aligned redirect.
    redirect = 1; redirect_target = 32'hBFC0_0102; tick();
    check("mis_fault", misalign_fault, 1'b1);
    check("mis_pc", pc, 32'hBFC0_0100);
    redirect = 0; tick(2);
    check("mis_hold_pc", pc, 32'hBFC0_0100);
    check("mis_hold_valid", valid_d, 1'b0);
    redirect = 1; redirect_target = 32'hBFC0_0200; tick();
    redirect = 0; tick();
    check("mis_exit_pc_d", pc_d, 32'hBFC0_0200);
    check("mis_sticky", misalign_fault, 1'b1);

    // Halt request pulse; the fetch in that cycle completes, then pc freezes.
    halt_req = 1; tick();
    halt_req = 0; tick(3);
    check("halt_pc", pc, 32'hBFC0_0208);
    check("halt_valid", valid_d, 1'b0);
    redirect = 1; redirect_target = 32'hBFC0_0040; tick();
    redirect = 0; tick();
    check("halt_exit_pc_d", pc_d, 32'hBFC0_0040);
    check("halt_exit_valid", valid_d, 1'b1);

    // Mixed stall/halt pattern, checked by the model.
    for (int i = 0; i < 16; i++) begin
      stall    = (i % 3 == 1);
      halt_req = (i == 11);
      tick();
    end
    stall = 0; halt_req = 0;
    redirect = 1; redirect_target = 32'hFFFF_FFFC; tick();
    redirect = 0; tick();
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_pc4", pc_plus4_d, 32'h0000_0000);
    tick(2);

    // Asynchronous reset mid-cycle with a redirect in flight.
    redirect = 1; redirect_target = 32'h0000_0080;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("async_pc", pc, RPC);
    check("async_valid", valid_d, 1'b0);
    check("async_instr", instr_d, NOP);
    check("async_count", fetch_count, 0);
    check("async_fault", misalign_fault, 1'b0);
    check("async_pc_d", pc_d, 0);
    tick();
    redirect = 0; rst_n = 1'b1;
    tick();
    check("reboot_pc", pc, RPC);
    tick(2);
    check("reboot_instr", instr_d, 32'h403F_FFFB);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
